// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: arbiter state encoding and
// an elaboration-time ceil(log2) helper.
package fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// FIFO read-port and consumer handshake bundle seen by the read-side arbiter.
// master = arbiter side, slave = FIFO/consumer side.
interface fifo_rd_arbiter_if #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned NREQ  = 4
);
  logic             rempty;
  logic             arempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  m_ready;
  logic [NREQ-1:0]  m_valid;
  logic [DSIZE-1:0] m_data;
  logic [NREQ-1:0]  grant;
  logic             busy;
  logic             burst_done;

  modport master (
    input  rempty, arempty, rdata, req, m_ready,
    output rinc, m_valid, m_data, grant, busy, burst_done
  );

  modport slave (
    output rempty, arempty, rdata, req, m_ready,
    input  rinc, m_valid, m_data, grant, busy, burst_done
  );
endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after i_ptr,
// wrapping modulo N.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot_c,
  output logic [IW-1:0] o_idx_c,
  output logic          o_any_c
);

  int unsigned w_k;

  always_comb begin
    o_onehot_c = '0;
    o_idx_c    = '0;
    o_any_c    = 1'b0;
    w_k        = 0;
    for (int unsigned off = 0; off < N; off++) begin
      w_k = (32'(i_ptr) + off) % N;
      if (!o_any_c && i_req[IW'(w_k)]) begin
        o_any_c = 1'b1;
        o_idx_c = IW'(w_k);
      end
    end
    if (o_any_c) o_onehot_c = N'(1) << o_idx_c;
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO read port between NREQ
// consumers in the read clock domain.
module fifo_rd_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE         = 8,
  parameter int unsigned NREQ          = 4,
  parameter int unsigned MAXBURST      = 4,
  parameter int unsigned EMPTY_RELEASE = 1
) (
  input  logic          rclk,
  input  logic          rrst,
  fifo_rd_arbiter_if.master bus
);

  localparam int unsigned   IW        = clog2(NREQ);
  localparam int unsigned   CW        = clog2(MAXBURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAXBURST - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

  arb_state_e      r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_rr;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_grant;
  logic            r_burst_done;

  logic [NREQ-1:0] w_pick_oh;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic            w_act;
  logic            w_xfer;
  logic            w_last;
  logic            w_withdraw;
  logic            w_empty_rel;
  logic            w_exit;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .i_req      (bus.req),
    .i_ptr      (r_rr),
    .o_onehot_c (w_pick_oh),
    .o_idx_c    (w_pick_idx),
    .o_any_c    (w_pick_any)
  );

  // Reset gates the handshake so no word is consumed in the reset cycle.
  assign w_act       = (r_state == ST_BURST) && !rrst;
  assign w_xfer      = w_act && !bus.rempty && bus.m_ready[r_owner];
  assign w_last      = w_xfer && (r_cnt == LAST_BEAT);
  assign w_withdraw  = !bus.req[r_owner] && !w_xfer;
  assign w_empty_rel = (EMPTY_RELEASE != 0) && (bus.rempty || (bus.arempty && w_xfer));
  assign w_exit      = w_last || w_withdraw || w_empty_rel;

  assign bus.rinc       = w_xfer;
  assign bus.m_valid    = (w_act && !bus.rempty) ? r_grant : '0;
  assign bus.m_data     = bus.rdata;
  assign bus.grant      = r_grant;
  assign bus.busy       = (r_state == ST_BURST);
  assign bus.burst_done = r_burst_done;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_rr         <= '0;
      r_cnt        <= '0;
      r_grant      <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any && !bus.rempty) begin
            r_state <= ST_BURST;
            r_owner <= w_pick_idx;
            r_grant <= w_pick_oh;
            r_cnt   <= '0;
            r_rr    <= (w_pick_idx == LAST_IDX) ? '0 : w_pick_idx + IW'(1);
          end
        end
        ST_BURST: begin
          if (w_xfer) r_cnt <= r_cnt + CW'(1);
          if (w_exit) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_burst_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Shares the read port of the async FIFO between NREQ consumers in the read clock domain.
- Grants bursts of up to MAXBURST words in round-robin order.
- Drives rinc from the granted consumer's valid/ready handshake, using rempty and arempty from the read-pointer/empty logic.
- Sits directly on the FIFO read side. rdata is combinational from raddr and is valid whenever !rempty.

Parameters:
- DSIZE, 8, FIFO data width.
- NREQ, 4, number of consumers (2..16).
- MAXBURST, 4, maximum words per grant (1..256).
- EMPTY_RELEASE, 1, 1 = release the grant when the FIFO empties mid-burst; 0 = hold the grant until burst done or req drop.

Ports:
- rclk  in  1  read-domain clock.
- rrst  in  1  synchronous reset, active-high.
- rempty  in  1  FIFO empty flag (registered, from read-pointer logic).
- arempty  in  1  FIFO almost-empty flag.
- rdata  in  DSIZE  FIFO read data, valid when !rempty.
- rinc  out  1  FIFO read increment.
- req  in  NREQ  per-consumer request, level.
- m_ready  in  NREQ  per-consumer ready.
- m_valid  out  NREQ  per-consumer valid, one-hot or zero.
- m_data  out  DSIZE  shared data bus, equal to rdata.
- grant  out  NREQ  current owner, one-hot or zero.
- busy  out  1  state == BURST.
- burst_done  out  1  one-cycle pulse on the cycle after the owner's grant ends.

Behaviour:
- States: IDLE, BURST. Internal registers: owner index, beat count cnt (clog2(MAXBURST+1) bits), round-robin pointer rr.
- Reset (rrst=1 at a rclk edge):
  - state=IDLE, grant=0, cnt=0, rr=0, burst_done=0.
  - m_valid=0 and rinc=0 combinationally from IDLE.
  - Reset mid-burst aborts the burst in the same edge. No rinc is issued in the reset cycle.
- IDLE:
  - If (|req) && !rempty: choose the first set req bit scanning rr, rr+1, …, wrapping modulo NREQ.
  - Register the owner and grant one-hot, set cnt=0, rr=owner+1 (mod NREQ), go to BURST.
  - This is one arbitration cycle; no data moves in IDLE.
- BURST:
  - m_valid[owner] = !rempty; other m_valid bits are 0.
  - m_data = rdata.
  - rinc = !rempty & m_ready[owner] (transfer).
  - On a transfer, cnt increments.
- BURST exit conditions, checked in priority order (exit happens at the clock edge):
  1. Transfer && cnt == MAXBURST-1: final beat; go to IDLE.
  2. !req[owner] && !transfer: consumer withdrew; go to IDLE.
  3. EMPTY_RELEASE && rempty: go to IDLE.
  4. Otherwise stay in BURST.
- Early release on almost-empty: if EMPTY_RELEASE && arempty && transfer, go to IDLE after this beat. The burst then ends without an idle empty cycle.
- On any exit: grant←0, burst_done←1 for exactly one cycle.
- Turnaround: at least one IDLE cycle between consecutive grants, including back-to-back grants to the same requester.
- A requester may drop req while m_valid is high and m_ready is low. The word is not consumed; rinc stays 0.
- m_ready on non-owners is ignored.
- rinc is never asserted when rempty=1. This guarantees no underflow independent of the pointer logic's own guard.
- req changes during BURST do not affect the owner.
- rr advances only on a grant, never on an exit.

Decomposition:
- Shared package fifo_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_BURST=1'b1.
  - clog2 function.
- One sub-module rr_pick (combinational: req vector and rr pointer in, one-hot and index out). It is reused by other arbiters in the design.
- Everything else lives in fifo_rd_arbiter.

Test Plan:
1. Reset mid-burst: consumer 0 in BURST with cnt=2, rrst=1 for 1 cycle → next cycle state IDLE, grant=0, rinc=0, rr=0. After rrst drops with req=0001 and FIFO not empty → grant=0001 two cycles later.
2. Round-robin fairness: NREQ=4, req=1111, FIFO holding 16 words, all m_ready=1, MAXBURST=4, EMPTY_RELEASE=0.
   - Grants must go 0,1,2,3, each exactly 4 rinc pulses, separated by one IDLE cycle.
   - burst_done pulses 4 times; FIFO empty at the end.
3. Backpressure: owner 2, m_ready[2] toggling 1,0,0,1,1,1 with FIFO not empty → rinc=1,0,0,1,1,1.
   - With MAXBURST=4, the grant ends after the 4th transfer.
   - m_data equals rdata on every rinc cycle.
4. Empty release: EMPTY_RELEASE=1, 2 words in FIFO, MAXBURST=4, req=0001 → 2 transfers, exit via arempty/rempty, then IDLE with grant=0.
   - With EMPTY_RELEASE=0 the grant is held with m_valid=0 until a 3rd word arrives.
5. Withdrawal: owner 1 drops req with m_ready=0 and m_valid=1 → next cycle IDLE, no rinc issued, word still in FIFO. Next grant goes to req 2 if it is set.
6. Simultaneous requests at wrap: rr=3, req=1001 → grant 3 first, then 0. When rempty=1 and req≠0, the block stays in IDLE indefinitely with rinc=0.
